// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR constants and sample/sum types
package fir_pkg;

  // Default sample width of the FIR datapath
  localparam int W = 16;

  // Half of the tap count; added before the divide to round half-up
  localparam int ROUND_BIAS = 2;

  // log2 of the tap count; the shift that turns a 4-tap sum into an average
  localparam int AVG_SHIFT = 2;

  typedef logic [W+1:0] sum_t;
  typedef logic [W-1:0] sample_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - small synchronous FIFO with occupancy and full/empty flags
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A pop on an empty FIFO is ignored; a push while full only lands if a pop frees the slot
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head entry, forced to zero so consumers see a clean bus when nothing is queued
  assign dout = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; level tracks net push/pop
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents need no reset since pointers and level gate visibility
  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fir4_decim_out.sv
// rtl/fir4_decim_out.sv - FIR output stage: rounding rescale, warm-up, decimation, output FIFO
module fir4_decim_out
  import fir_pkg::*;
#(
  parameter int w      = W,
  parameter int D      = 2,
  parameter int WARMUP = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [w+1:0]             s_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [w-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int WCW = $clog2(WARMUP + 1) + 1;
  localparam int PCW = $clog2(D) + 1;

  logic [WCW-1:0] warm_cnt;
  logic [PCW-1:0] phase;
  logic           warm_done;
  logic           keep;
  logic           pop_eff;
  logic           fifo_push;
  logic           fifo_full;
  logic           fifo_empty;
  logic [w+2:0]   avg_wide;
  logic [w-1:0]   avg;
  logic           avg_unused;

  // Round half-up average; one spare bit keeps the bias add from wrapping
  assign avg_wide   = {1'b0, s_in} + (w+3)'(ROUND_BIAS);
  assign avg        = avg_wide[AVG_SHIFT +: w];
  assign avg_unused = ^{avg_wide[w+2], avg_wide[AVG_SHIFT-1:0]};

  assign warm_done = (warm_cnt == WCW'(WARMUP));
  assign keep      = warm_done && (phase == PCW'(D - 1));
  assign out_valid = !fifo_empty;
  assign pop_eff   = out_valid && out_ready;

  // At full, a kept sample only gets in when the same cycle frees a slot
  assign fifo_push = keep && (!fifo_full || pop_eff);

  // Warm-up counter saturates at WARMUP; until then incoming sums are ignored
  always_ff @(posedge clk) begin
    if (!reset) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + WCW'(1);
    end
  end

  // Decimation phase runs 0..D-1 once warm-up is over; the last phase is the kept one
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= '0;
    end else if (warm_done) begin
      phase <= (phase == PCW'(D - 1)) ? '0 : phase + PCW'(1);
    end
  end

  // Sticky flag for a kept sample lost to a full FIFO with no pop to make room
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (keep && fifo_full && !pop_eff) begin
      overflow <= 1'b1;
    end
  end

  fir_sync_fifo #(
    .WIDTH (w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pop_eff),
    .din   (avg),
    .dout  (out_data),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fir4_decim_out.sv
// tb/tb_fir4_decim_out.sv - randomized self-checking bench for fir4_decim_out
module tb_fir4_decim_out;

  localparam int W      = 16;
  localparam int WARMUP = 5;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int SMAX   = 4 * ((1 << W) - 1);

  logic          clk = 1'b0;
  logic          reset0, reset1, rdy0, rdy1;
  logic [W+1:0]  s0, s1;
  logic          v0, v1, ov0, ov1;
  logic [W-1:0]  d0, d1;
  logic [LW-1:0] l0, l1;

  int checks   = 0;
  int failures = 0;

  int sel;
  int md;
  int q[$];
  int t;
  bit movf;

  always #5 clk = ~clk;

  fir4_decim_out #(.w(W), .D(2), .WARMUP(WARMUP), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset0), .s_in(s0), .out_valid(v0), .out_ready(rdy0),
    .out_data(d0), .level(l0), .overflow(ov0)
  );

  fir4_decim_out #(.w(W), .D(1), .WARMUP(WARMUP), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset1), .s_in(s1), .out_valid(v1), .out_ready(rdy1),
    .out_data(d1), .level(l1), .overflow(ov1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit will_keep();
    return (t >= WARMUP) && (((t - WARMUP) % md) == md - 1);
  endfunction

  task automatic drive(input bit rst, input int s, input bit rdy);
    logic [W+1:0] sv;
    sv = s[W+1:0];
    if (sel == 0) begin
      reset0 = rst; s0 = sv; rdy0 = rdy;
      reset1 = 1'b0; s1 = '0; rdy1 = 1'b0;
    end else begin
      reset1 = rst; s1 = sv; rdy1 = rdy;
      reset0 = 1'b0; s0 = '0; rdy0 = 1'b0;
    end
  endtask

  // Reference: count cycles since reset release, keep every md-th post-warm-up sample
  task automatic model_edge();
    bit r, rdy, pop, kp;
    int s;
    r   = (sel == 0) ? reset0 : reset1;
    rdy = (sel == 0) ? rdy0 : rdy1;
    s   = (sel == 0) ? int'(s0) : int'(s1);
    if (!r) begin
      q.delete();
      movf = 1'b0;
      t = 0;
    end else begin
      pop = (q.size() > 0) && rdy;
      kp  = will_keep();
      if (pop) void'(q.pop_front());
      if (kp) begin
        if (q.size() == DEPTH) movf = 1'b1;
        else q.push_back((s + 2) / 4);
      end
      t++;
    end
  endtask

  task automatic compare();
    int ev, ed;
    ev = (q.size() > 0) ? 1 : 0;
    ed = (q.size() > 0) ? q[0] : 0;
    if (sel == 0) begin
      check("valid", v0, ev);
      check("data", d0, ed);
      check("level", l0, q.size());
      check("overflow", ov0, movf);
    end else begin
      check("valid_d1", v1, ev);
      check("data_d1", d1, ed);
      check("level_d1", l1, q.size());
      check("overflow_d1", ov1, movf);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  function automatic bit act_valid();
    return (sel == 0) ? v0 : v1;
  endfunction

  // Releases reset and counts cycles until the first out_valid; -1 if it never comes
  task automatic first_valid(input int s, output int first);
    first = -1;
    for (int n = 1; n <= 40; n++) begin
      drive(1, s, 1);
      step();
      if (first < 0 && act_valid()) first = n;
    end
  endtask

  initial begin
    int first;
    int rv[3];
    bit k;
    rv[0] = 5; rv[1] = 6; rv[2] = SMAX;
    sel = 0; md = 2; t = 0; movf = 1'b0;
    drive(0, 0, 0);

    // Reset state
    repeat (3) step();
    check("reset_level", l0, 0);
    check("reset_valid", v0, 0);
    check("reset_data", d0, 0);
    check("reset_overflow", ov0, 0);

    // Constant input with consumer always ready
    first = -1;
    for (int n = 1; n <= 30; n++) begin
      drive(1, 400, 1);
      step();
      if (first < 0 && v0) first = n;
      if (v0) check("const_data", d0, 100);
      check("const_level_le1", (l0 <= 1), 1);
    end
    check("const_first_out", first, WARMUP + 2);

    // Rounding corner values
    for (int i = 0; i < 24; i++) begin
      drive(1, rv[i % 3], 1);
      step();
    end

    // Fill past full with no consumer, then drain
    drive(0, 0, 0); step();
    for (int i = 0; i < WARMUP + 10; i++) begin
      drive(1, $urandom_range(0, SMAX), 0);
      step();
    end
    check("fill_level_full", l0, DEPTH);
    check("fill_overflow", ov0, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1, $urandom_range(0, SMAX), 1);
      step();
    end

    // Push and pop in the same cycle while full
    drive(0, 0, 0); step();
    for (int i = 0; i < 40 && q.size() < DEPTH; i++) begin
      drive(1, $urandom_range(0, SMAX), 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      k = will_keep();
      drive(1, $urandom_range(0, SMAX), k);
      step();
      if (k) break;
    end
    check("pushpop_full_level", l0, DEPTH);
    check("pushpop_full_overflow", ov0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, $urandom_range(0, SMAX), 1);
      step();
    end

    // Reset mid-stream with level 3 and overflow set
    drive(0, 0, 0); step();
    for (int i = 0; i < WARMUP + 10; i++) begin
      drive(1, $urandom_range(0, SMAX), 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      k = will_keep();
      drive(1, $urandom_range(0, SMAX), !k);
      step();
      if (!k) break;
    end
    check("mid_level_before", l0, 3);
    check("mid_overflow_before", ov0, 1);
    drive(0, $urandom_range(0, SMAX), 1);
    step();
    check("mid_level_after", l0, 0);
    check("mid_valid_after", v0, 0);
    check("mid_data_after", d0, 0);
    check("mid_overflow_after", ov0, 0);
    first_valid(1000, first);
    check("mid_first_out", first, WARMUP + 2);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 60) != 0, $urandom_range(0, SMAX), $urandom_range(0, 1));
      step();
    end

    // No decimation: ramp input, one output per cycle
    sel = 1; md = 1;
    drive(0, 0, 0); step(); step();
    first = -1;
    for (int n = 1; n <= 40; n++) begin
      drive(1, 4 * (n - 1), 1);
      step();
      if (first < 0 && v1) first = n;
      if (n > WARMUP) check("ramp_data", d1, n - 1 - WARMUP + WARMUP);
    end
    check("ramp_first_out", first, WARMUP + 1);
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 60) != 0, $urandom_range(0, SMAX), $urandom_range(0, 1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
